// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch stall and flush, multi-cycle Execute FSM.
// Optional stall/flush performance counters are built only when HAZARD_PERF_EN is defined.
//
// state  | meaning
// IDLE   | no multi-cycle op holds Execute (a starting op is flagged combinationally)
// BUSY   | multi-cycle op draining; r_cnt counts the remaining Execute cycles
module hazard_unit_mc #(
    parameter int ADDR_W = 6,
    parameter int NUM_RP = 2,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_reg_write_m,
    input  logic                     i_reg_write_w,
    input  logic                     i_mem_to_reg_e,
    input  logic                     i_multi_cycle_e,
    input  logic                     i_branch_taken_e,
    input  logic                     i_pcsrc_d,
    input  logic                     i_pcsrc_e,
    input  logic                     i_pcsrc_m,
    input  logic                     i_pcsrc_w,
    input  logic [NUM_RP*ADDR_W-1:0] i_ra_d,
    input  logic [NUM_RP*ADDR_W-1:0] i_ra_e,
    input  logic [ADDR_W-1:0]        i_wa3_e,
    input  logic [ADDR_W-1:0]        i_wa3_m,
    input  logic [ADDR_W-1:0]        i_wa3_w,
    output logic [2*NUM_RP-1:0]      o_forward_e,
    output logic                     o_stall_f,
    output logic                     o_stall_d,
    output logic                     o_stall_e,
    output logic                     o_flush_d,
    output logic                     o_flush_e,
    output logic                     o_mc_busy,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_flush_cnt
);

    localparam int            CW       = $clog2(MC_LAT) + 1;
    localparam bit            MC_EN    = (MC_LAT > 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [2*NUM_RP-1:0] w_fwd;
    logic                w_ldrstall;
    logic                w_pcpend;
    logic                w_flush_e_idle;
    logic                w_mc_start;
    logic                w_mc_busy;
    logic                w_stall_f;
    logic                w_stall_d;
    logic                w_stall_e;
    logic                w_flush_d;
    logic                w_flush_e;

    // Memory stage result is younger than Writeback, so it takes priority.
    always_comb begin
        w_fwd      = '0;
        w_ldrstall = 1'b0;
        for (int i = 0; i < NUM_RP; i++) begin
            if (i_reg_write_m && (i_ra_e[i*ADDR_W +: ADDR_W] == i_wa3_m))
                w_fwd[2*i +: 2] = 2'b10;
            else if (i_reg_write_w && (i_ra_e[i*ADDR_W +: ADDR_W] == i_wa3_w))
                w_fwd[2*i +: 2] = 2'b01;
            if (i_ra_d[i*ADDR_W +: ADDR_W] == i_wa3_e)
                w_ldrstall = i_mem_to_reg_e;
        end
    end

    assign w_pcpend       = i_pcsrc_d | i_pcsrc_e | i_pcsrc_m;
    assign w_flush_e_idle = w_ldrstall | i_branch_taken_e;
    // An op being flushed out of Execute must not start the FSM.
    assign w_mc_start     = MC_EN && (r_state == S_IDLE) && i_multi_cycle_e && !w_flush_e_idle;
    assign w_mc_busy      = (r_state == S_BUSY) || w_mc_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_mc_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1))
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // While busy, load-use and PC hazards are simply held back until the op drains.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (i_reset) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_mc_busy) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
        end else begin
            w_stall_f = w_ldrstall | w_pcpend;
            w_flush_d = w_pcpend | i_pcsrc_w | i_branch_taken_e;
            w_flush_e = w_flush_e_idle;
            w_stall_d = w_ldrstall & ~w_flush_d;
        end
    end

    assign o_forward_e = i_reset ? '0 : w_fwd;
    assign o_mc_busy   = w_mc_busy & ~i_reset;
    assign o_stall_f   = w_stall_f;
    assign o_stall_d   = w_stall_d;
    assign o_stall_e   = w_stall_e;
    assign o_flush_d   = w_flush_d;
    assign o_flush_e   = w_flush_e;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_d && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_e && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
